prince_affine_share_pipe: RTL and testbench

- Parameterised, elastic-pipelined affine layer for the masked PRINCE datapath.
- Applies the A1 nibble affine map, or its inverse, to every nibble of every share of a threshold-implementation state.
- Adds the affine constant to share 0 only, so the XOR of all shares is transformed by the full affine map A1.
- Sits between the shared S-box quadratic stages. Carries valid/ready backpressure through a configurable number of register stages.

---
 rtl/prince_ti_pkg.sv | 14 +
 rtl/prince_a1_nibble_map.sv | 29 ++
 rtl/prince_affine_share_pipe.sv | 104 ++++++++++
 tb/tb_prince_affine_share_pipe.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prince_ti_pkg.sv
// Shared definitions for the threshold-implementation PRINCE datapath blocks.
package prince_ti_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  // Bit offset of nibble n of share s inside a concatenated shared state.
  function automatic int nibble_lsb(input int s, input int n, input int nibbles);
    return (s * nibbles + n) * NIBBLE_W;
  endfunction

endpackage

// File: rtl/prince_a1_nibble_map.sv
// One nibble of the A1 affine layer, forward or inverse, applied to a single share.
// The affine constant is folded in only on share 0.
module prince_a1_nibble_map
  import prince_ti_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic                mode,
  input  logic                is_share0,
  output logic [NIBBLE_W-1:0] y
);

  // Select forward or inverse bit equations; the constant only touches bits 3 and 2.
  always_comb begin
    // NOTE: assign a default before any branch so a missed path cannot infer a latch.
    y = '0;
    if (mode == MODE_FWD) begin
      y[3] = is_share0 ^ x[3] ^ x[1];
      y[2] = is_share0 ^ x[2];
      y[1] = x[1] ^ x[0];
      y[0] = x[1];
    end else begin
      y[3] = is_share0 ^ x[3] ^ x[0];
      y[2] = is_share0 ^ x[2];
      y[1] = x[0];
      y[0] = x[1] ^ x[0];
    end
  end

endmodule

// File: rtl/prince_affine_share_pipe.sv
// Elastic pipelined A1 affine layer over all shares of a masked PRINCE state.
// The map is computed combinationally ahead of stage 1; stages carry valid/ready.
module prince_affine_share_pipe
  import prince_ti_pkg::*;
#(
  parameter int SHARES  = 3,
  parameter int NIBBLES = 16,
  parameter int STAGES  = 2,
  parameter int CNT_W   = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_mode,
  input  logic [SHARES*NIBBLES*NIBBLE_W-1:0] in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_mode,
  output logic [SHARES*NIBBLES*NIBBLE_W-1:0] out_data,
  output logic [CNT_W-1:0]                   beat_cnt
);

  localparam int W = SHARES * NIBBLES * NIBBLE_W;

  logic [W-1:0]        mapped;
  logic [STAGES-1:0]   v_q;
  logic [STAGES-1:0]   mode_q;
  logic [W-1:0]        data_q [STAGES];
  logic [STAGES-1:0]   adv;
  logic [STAGES-1:0]   src_v;
  logic [STAGES-1:0]   src_mode;
  logic [W-1:0]        src_data [STAGES];
  logic [CNT_W-1:0]    cnt_q;

  // Per-share, per-nibble map; shares never mix, so non-completeness holds.
  for (genvar s = 0; s < SHARES; s++) begin : g_share
    for (genvar n = 0; n < NIBBLES; n++) begin : g_nib
      localparam int LSB = nibble_lsb(s, n, NIBBLES);
      prince_a1_nibble_map u_map (
        .x        (in_data[LSB +: NIBBLE_W]),
        .mode     (in_mode),
        .is_share0(1'(s == 0)),
        .y        (mapped[LSB +: NIBBLE_W])
      );
    end
  end

  // A stage may load when it is empty or the stage after it moves on this cycle.
  always_comb begin : advance_chain
    logic free;
    free = out_ready;
    adv  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      free   = !v_q[k] | free;
      adv[k] = free;
    end
  end

  // Source of each stage: the mapped input for stage 1, the previous stage otherwise.
  always_comb begin
    src_v    = '0;
    src_mode = '0;
    src_data = '{default: '0};
    src_v[0]    = in_valid;
    src_mode[0] = in_mode;
    src_data[0] = mapped;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k]    = v_q[k-1];
      src_mode[k] = mode_q[k-1];
      src_data[k] = data_q[k-1];
    end
  end

  // Stage registers and beat counter; data only moves with a valid beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: data registers are cleared too, so out_data reads 0 after reset.
      v_q    <= '0;
      mode_q <= '0;
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
      cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking updates let every stage see the pre-edge value of its source.
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          v_q[k] <= src_v[k];
          if (src_v[k]) begin
            data_q[k] <= src_data[k];
            mode_q[k] <= src_mode[k];
          end
        end
      end
      if (v_q[STAGES-1] && out_ready) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign in_ready  = rst_n & adv[0];
  assign out_valid = v_q[STAGES-1];
  assign out_mode  = mode_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_prince_affine_share_pipe.sv
// Directed bench for the shared A1 affine pipeline with a scoreboard of expected beats.
module tb_prince_affine_share_pipe;

  localparam int SHARES  = 3;
  localparam int NIBBLES = 16;
  localparam int STAGES  = 2;
  localparam int CNT_W   = 4;
  localparam int W       = SHARES * NIBBLES * 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_mode;
  logic [W-1:0]     out_data;
  logic [CNT_W-1:0] beat_cnt;

  typedef struct packed {
    logic         mode;
    logic [W-1:0] data;
    logic [63:0]  um;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   sent   = 0;
  int   rcvd   = 0;

  prince_affine_share_pipe #(
    .SHARES (SHARES),
    .NIBBLES(NIBBLES),
    .STAGES (STAGES),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mode (out_mode),
    .out_data (out_data),
    .beat_cnt (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A1 nibble equations (forward / inverse) with constant c.
  function automatic logic [3:0] a1_nib(input logic [3:0] x, input logic mode, input logic c);
    if (!mode) return {c ^ x[3] ^ x[1], c ^ x[2], x[1] ^ x[0], x[1]};
    else       return {c ^ x[3] ^ x[0], c ^ x[2], x[0], x[1] ^ x[0]};
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic mode);
    logic [W-1:0] r;
    r = '0;
    for (int s = 0; s < SHARES; s++)
      for (int n = 0; n < NIBBLES; n++)
        r[(s*NIBBLES+n)*4 +: 4] = a1_nib(d[(s*NIBBLES+n)*4 +: 4], mode, (s == 0));
    return r;
  endfunction

  function automatic logic [63:0] unmask(input logic [W-1:0] d);
    logic [63:0] u;
    u = '0;
    for (int s = 0; s < SHARES; s++) u ^= d[s*64 +: 64];
    return u;
  endfunction

  function automatic logic [63:0] model64(input logic [63:0] u, input logic mode);
    logic [63:0] r;
    r = '0;
    for (int n = 0; n < 16; n++) r[n*4 +: 4] = a1_nib(u[n*4 +: 4], mode, 1'b1);
    return r;
  endfunction

  function automatic logic [W-1:0] pattern(input int k);
    logic [W-1:0] d;
    d = '0;
    for (int j = 0; j < W/4; j++) d[j*4 +: 4] = 4'(k * 5 + j * 7 + 3);
    return d;
  endfunction

  // Settle, account for handshakes about to happen, then advance one edge.
  task automatic tick();
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", out_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        check("sb_data", out_data, e.data);
        check("sb_mode", out_mode, e.mode);
        check("sb_unmask", unmask(out_data), e.um);
        rcvd++;
      end
    end
    if (in_valid && in_ready) begin
      e.mode = in_mode;
      e.data = model(in_data, in_mode);
      e.um   = model64(unmask(in_data), in_mode);
      sb.push_back(e);
      sent++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    sent  = 0;
    rcvd  = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] held;
    logic [W-1:0] d;
    logic [11:0]  iv;
    int           hold;
    bit           first;
    bit           w16;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_mode", out_mode, 1'b0);
    check("rst_beat_cnt", beat_cnt, '0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Forward map, no backpressure
    in_valid  = 1'b1;
    in_mode   = 1'b0;
    in_data   = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("fwd_lat1_valid", out_valid, 1'b0);
    tick();
    check("fwd_valid", out_valid, 1'b1);
    check("fwd_data", out_data, {64'h0, 64'h5555_5555_5555_5555, 64'hCCCC_CCCC_CCCC_CCCC});
    check("fwd_mode", out_mode, 1'b0);
    tick();
    check("fwd_cnt", beat_cnt, 4'd1);
    check("fwd_drained", out_valid, 1'b0);

    // Inverse round trip
    in_valid = 1'b1;
    in_mode  = 1'b1;
    in_data  = {64'h0, 64'h5555_5555_5555_5555, 64'hCCCC_CCCC_CCCC_CCCC};
    tick();
    in_valid = 1'b0;
    tick();
    check("inv_valid", out_valid, 1'b1);
    check("inv_data", out_data, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
    check("inv_mode", out_mode, 1'b1);
    tick();
    check("inv_cnt", beat_cnt, 4'd2);

    // Exhaustive 3-share nibble sweep, mixed modes, full rate
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      iv = 12'(i);
      d  = '0;
      for (int s = 0; s < SHARES; s++)
        for (int n = 0; n < NIBBLES; n++)
          d[(s*NIBBLES+n)*4 +: 4] = iv[s*4 +: 4] ^ 4'(n);
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = ^iv;
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20 && sb.size() > 0; c++) tick();
    check("sweep_rcvd", rcvd, 4096);

    // Backpressure: 6 beats, out_ready low for 5 cycles from first output
    do_reset();
    first = 1'b0;
    hold  = 0;
    for (int c = 0; c < 60 && rcvd < 6; c++) begin
      in_valid = (sent < 6);
      in_data  = pattern(sent);
      in_mode  = 1'(sent % 2);
      if (out_valid && !first) begin
        first = 1'b1;
        hold  = 5;
        held  = out_data;
      end
      out_ready = (hold == 0);
      if (hold > 0) begin
        #1;
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_hold_data", out_data, held);
        hold--;
      end
      tick();
    end
    check("bp_rcvd", rcvd, 6);
    check("bp_cnt", beat_cnt, 4'd6);

    // Full throughput with simultaneous handshakes
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      in_data  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      in_mode  = 1'($urandom_range(0, 1));
      #1;
      check("tp_in_ready", in_ready, 1'b1);
      if (c >= STAGES) check("tp_no_bubble", out_valid, 1'b1);
      tick();
    end
    check("tp_outputs", rcvd + int'(out_valid), 20 - STAGES + 1);
    in_valid = 1'b0;
    for (int c = 0; c < 10 && sb.size() > 0; c++) tick();
    check("tp_rcvd", rcvd, 20);
    check("tp_cnt", beat_cnt, 4'd4);

    // Reset with two beats in flight
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = pattern(c + 40);
      in_mode  = (c == 3);
      tick();
    end
    check("mr_pre_cnt", beat_cnt, 4'd3);
    check("mr_pre_mode", out_mode, 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    check("mr_out_valid", out_valid, 1'b0);
    check("mr_out_data", out_data, '0);
    check("mr_out_mode", out_mode, 1'b0);
    check("mr_cnt", beat_cnt, '0);
    rst_n = 1'b1;
    #1;
    check("mr_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("mr_no_ghost", out_valid, 1'b0);
    end

    // Counter wrap at 2^CNT_W
    do_reset();
    out_ready = 1'b1;
    w16 = 1'b0;
    for (int c = 0; c < 40 && rcvd < 17; c++) begin
      in_valid = (sent < 17);
      in_data  = pattern(c + 100);
      in_mode  = 1'(c % 3 == 0);
      tick();
      if (rcvd == 16 && !w16) begin
        w16 = 1'b1;
        check("wrap_16", beat_cnt, 4'd0);
      end
      if (rcvd == 17) check("wrap_17", beat_cnt, 4'd1);
    end
    check("wrap_rcvd", rcvd, 17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
